mu_gpio_irq: RTL and testbench

- Parametrised successor to the fixed 32-bit APB GPIO used for AFE bit-banging and DSI LP muxing.
- Adds:
  - configurable pin count;
  - atomic set/clear/toggle output writes;
  - a multi-stage input synchroniser;
  - a shared-prescaler debounce filter;
  - per-pin rise/fall edge capture into a W1C status register, driving one level interrupt.
- Sits on one APB slot of apbbus, in the clk domain.

---
 rtl/mu_gpio_irq_pkg.sv | 29 ++
 rtl/mu_gpio_irq_if.sv | 18 +
 rtl/mu_sync_debounce.sv | 62 ++++++
 rtl/mu_gpio_irq.sv | 110 +++++++++++
 tb/tb_mu_gpio_irq.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/mu_gpio_irq_pkg.sv
// Shared definitions for the APB GPIO block with edge interrupts.
// Contents:
//   - the register word-offset enumeration, decoded from paddr[5:2]
//   - the ID register constants
//   - a helper that builds the ID readback word
package mu_gpio_irq_pkg;

    typedef enum logic [3:0] {
        GPIO_REG_OUT     = 4'h0,
        GPIO_REG_SET     = 4'h1,
        GPIO_REG_CLR     = 4'h2,
        GPIO_REG_TGL     = 4'h3,
        GPIO_REG_OE      = 4'h4,
        GPIO_REG_IN      = 4'h5,
        GPIO_REG_RISE_EN = 4'h6,
        GPIO_REG_FALL_EN = 4'h7,
        GPIO_REG_STAT    = 4'h8,
        GPIO_REG_DB      = 4'h9,
        GPIO_REG_ID      = 4'hA
    } gpio_reg_e;

    localparam logic [15:0] GPIO_ID_MAGIC = 16'h4750;
    localparam logic [7:0]  GPIO_ID_VER   = 8'h01;

    function automatic logic [31:0] gpio_id(input int n);
        return {GPIO_ID_MAGIC, GPIO_ID_VER, 8'(n)};
    endfunction

endpackage

// File: rtl/mu_gpio_irq_if.sv
// APB slave bus bundle for mu_gpio_irq.
// Signals:
//   - psel/penable/pwrite, paddr, pwdata : driven by the master
//   - pready, prdata                      : returned by the slave
interface mu_gpio_irq_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;

    modport master (output psel, penable, pwrite, paddr, pwdata,
                    input  pready, prdata);
    modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                    output pready, prdata);
endinterface

// File: rtl/mu_sync_debounce.sv
// Input synchroniser followed by a prescaled debounce filter.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   in_i       : asynchronous pin inputs
//   db_i       : prescaler terminal count; 0 bypasses the filter
//   db_wr_i    : DB register write strobe; restarts the prescaler and
//                clears the histories
//   filt_o     : filtered pin values
module mu_sync_debounce #(
    parameter int W           = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [W-1:0]    in_i,
    input  logic [DB_W-1:0] db_i,
    input  logic            db_wr_i,
    output logic [W-1:0]    filt_o
);

    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [DB_W-1:0]               cnt_q;
    logic [W-1:0]                  h0_q, h1_q, filt_q;
    logic [W-1:0]                  sync, stable;
    logic                          tick;

    assign sync   = sync_q[SYNC_STAGES-1];
    assign tick   = (cnt_q == db_i);
    // Current sample agrees with the two previous tick samples.
    assign stable = ~(sync ^ h0_q) & ~(h0_q ^ h1_q);
    assign filt_o = filt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            h0_q   <= '0;
            h1_q   <= '0;
            filt_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
            if (db_wr_i) begin
                // filt deliberately holds across a DB change
                cnt_q <= '0;
                h0_q  <= '0;
                h1_q  <= '0;
            end else if (db_i == '0) begin
                filt_q <= sync;
                cnt_q  <= '0;
            end else if (tick) begin
                cnt_q  <= '0;
                h1_q   <= h0_q;
                h0_q   <= sync;
                filt_q <= (filt_q & ~stable) | (sync & stable);
            end else begin
                cnt_q <= cnt_q + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/mu_gpio_irq.sv
// APB GPIO with atomic set/clear/toggle, synchronised and debounced
// inputs, and per-pin rise/fall capture into a W1C status register that
// drives one level interrupt.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   s_apb      : APB slave bus (zero wait state)
//   gpio_in    : asynchronous pin inputs
//   gpio_out   : OUT register
//   gpio_oe    : OE register
//   irq        : registered OR of STAT
module mu_gpio_irq
    import mu_gpio_irq_pkg::*;
#(
    parameter int          N           = 32,
    parameter int          SYNC_STAGES = 2,
    parameter int          DB_W        = 16,
    parameter logic [31:0] RST_OUT     = 32'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    mu_gpio_irq_if.slave  s_apb,
    input  logic [N-1:0]  gpio_in,
    output logic [N-1:0]  gpio_out,
    output logic [N-1:0]  gpio_oe,
    output logic          irq
);

    logic [N-1:0]    out_q, oe_q, rise_en_q, fall_en_q, stat_q, filt_d_q;
    logic [DB_W-1:0] db_q;
    logic            irq_q;
    logic [N-1:0]    filt, wdata, w1c, rise, fall;
    logic            acc, wr, db_wr;
    gpio_reg_e       idx;

    assign acc   = s_apb.psel & s_apb.penable;
    assign wr    = acc & s_apb.pwrite;
    assign idx   = gpio_reg_e'(s_apb.paddr[5:2]);
    assign wdata = s_apb.pwdata[N-1:0];
    assign db_wr = wr && (idx == GPIO_REG_DB);
    assign w1c   = (wr && idx == GPIO_REG_STAT) ? wdata : '0;
    assign rise  =  filt & ~filt_d_q & rise_en_q;
    assign fall  = ~filt &  filt_d_q & fall_en_q;

    assign s_apb.pready = acc;
    assign gpio_out     = out_q;
    assign gpio_oe      = oe_q;
    assign irq          = irq_q;

    mu_sync_debounce #(
        .W           (N),
        .SYNC_STAGES (SYNC_STAGES),
        .DB_W        (DB_W)
    ) u_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_i    (gpio_in),
        .db_i    (db_q),
        .db_wr_i (db_wr),
        .filt_o  (filt)
    );

    always_comb begin
        s_apb.prdata = '0;
        if (acc) begin
            case (idx)
                GPIO_REG_OUT:     s_apb.prdata = 32'(out_q);
                GPIO_REG_OE:      s_apb.prdata = 32'(oe_q);
                GPIO_REG_IN:      s_apb.prdata = 32'(filt);
                GPIO_REG_RISE_EN: s_apb.prdata = 32'(rise_en_q);
                GPIO_REG_FALL_EN: s_apb.prdata = 32'(fall_en_q);
                GPIO_REG_STAT:    s_apb.prdata = 32'(stat_q);
                GPIO_REG_DB:      s_apb.prdata = 32'(db_q);
                GPIO_REG_ID:      s_apb.prdata = gpio_id(N);
                default:          s_apb.prdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= RST_OUT[N-1:0];
            oe_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            stat_q    <= '0;
            db_q      <= '0;
            filt_d_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            if (wr) begin
                case (idx)
                    GPIO_REG_OUT:     out_q     <= wdata;
                    GPIO_REG_SET:     out_q     <= out_q | wdata;
                    GPIO_REG_CLR:     out_q     <= out_q & ~wdata;
                    GPIO_REG_TGL:     out_q     <= out_q ^ wdata;
                    GPIO_REG_OE:      oe_q      <= wdata;
                    GPIO_REG_RISE_EN: rise_en_q <= wdata;
                    GPIO_REG_FALL_EN: fall_en_q <= wdata;
                    GPIO_REG_DB:      db_q      <= s_apb.pwdata[DB_W-1:0];
                    default: ;
                endcase
            end
            filt_d_q <= filt;
            // new edges are OR'd in after the W1C mask, so a set wins
            stat_q   <= (stat_q & ~w1c) | rise | fall;
            irq_q    <= |stat_q;
        end
    end

endmodule

// File: tb/tb_mu_gpio_irq.sv
// Self-checking bench for mu_gpio_irq: an N=32 instance for the
// functional and timing cases, an N=8 instance for masking and
// mid-access reset. Read expectations are queued, then popped and
// compared when the read data arrives.
module tb_mu_gpio_irq;

    logic        clk = 1'b0;
    logic        rst32_n = 1'b0;
    logic        rst8_n  = 1'b0;
    logic [31:0] gin32 = '0;
    logic [7:0]  gin8  = '0;
    logic [31:0] gout32, goe32;
    logic [7:0]  gout8, goe8;
    logic        irq32, irq8;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    mu_gpio_irq_if if32 ();
    mu_gpio_irq_if if8 ();

    mu_gpio_irq #(.N(32)) u_dut32 (
        .clk(clk), .rst_n(rst32_n), .s_apb(if32),
        .gpio_in(gin32), .gpio_out(gout32), .gpio_oe(goe32), .irq(irq32)
    );

    mu_gpio_irq #(.N(8), .RST_OUT(32'hA5)) u_dut8 (
        .clk(clk), .rst_n(rst8_n), .s_apb(if8),
        .gpio_in(gin8), .gpio_out(gout8), .gpio_oe(goe8), .irq(irq8)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=0x%08h exp=0x%08h", tag, act, exp);
        end
    endtask

    task automatic drv(input bit b8, input logic ps, input logic pe, input logic pw,
                       input logic [31:0] a, input logic [31:0] d);
        if (b8) begin
            if8.psel = ps; if8.penable = pe; if8.pwrite = pw; if8.paddr = a; if8.pwdata = d;
        end else begin
            if32.psel = ps; if32.penable = pe; if32.pwrite = pw; if32.paddr = a; if32.pwdata = d;
        end
    endtask

    // Write commits on the third clock edge after the call.
    task automatic apb_wr(input bit b8, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        drv(b8, 1'b1, 1'b0, 1'b1, a, d);
        @(posedge clk); #1;
        drv(b8, 1'b1, 1'b1, 1'b1, a, d);
        #1;
        chk("pready_wr", 32'(b8 ? if8.pready : if32.pready), 32'h1);
        @(posedge clk); #1;
        drv(b8, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic apb_rd(input bit b8, input logic [31:0] a, input string tag);
        logic [31:0] d;
        logic [31:0] e;
        @(posedge clk); #1;
        drv(b8, 1'b1, 1'b0, 1'b0, a, '0);
        @(posedge clk); #1;
        drv(b8, 1'b1, 1'b1, 1'b0, a, '0);
        #1;
        d = b8 ? if8.prdata : if32.prdata;
        chk("pready_rd", 32'(b8 ? if8.pready : if32.pready), 32'h1);
        if (exp_q.size() == 0) begin
            chk({tag, "_noexp"}, d, ~d);
        end else begin
            e = exp_q.pop_front();
            chk(tag, d, e);
        end
        @(posedge clk); #1;
        drv(b8, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic rd_exp(input bit b8, input logic [31:0] a, input logic [31:0] e,
                          input string tag);
        exp_q.push_back(e);
        apb_rd(b8, a, tag);
    endtask

    initial begin
        int k;
        drv(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        drv(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        rst32_n = 1'b1;
        rst8_n  = 1'b1;

        // reset state
        chk("rst_gout", gout32, 32'h0);
        chk("rst_goe",  goe32,  32'h0);
        chk("rst_irq",  32'(irq32), 32'h0);
        chk("rst_gout8", 32'(gout8), 32'hA5);
        rd_exp(1'b0, 32'h28, 32'h47500120, "id32");
        rd_exp(1'b1, 32'h28, 32'h47500108, "id8");

        // atomic output writes
        apb_wr(1'b0, 32'h00, 32'h0000FF00); chk("gout_wr",  gout32, 32'h0000FF00);
        apb_wr(1'b0, 32'h04, 32'h00000001); chk("gout_set", gout32, 32'h0000FF01);
        apb_wr(1'b0, 32'h08, 32'h00000100); chk("gout_clr", gout32, 32'h0000FE01);
        apb_wr(1'b0, 32'h0C, 32'h80000001); chk("gout_tgl", gout32, 32'h8000FE00);
        rd_exp(1'b0, 32'h00, 32'h8000FE00, "out_rd");
        rd_exp(1'b0, 32'h04, 32'h0, "set_rd");
        apb_wr(1'b0, 32'h10, 32'h0000F0F0); chk("goe", goe32, 32'h0000F0F0);

        // bypass path: pin 2 rise
        apb_wr(1'b0, 32'h18, 32'h4);
        @(posedge clk); #1; gin32[2] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; chk("filt_e2", 32'(u_dut32.filt[2]), 32'h0);
        @(posedge clk); #1; chk("filt_e3", 32'(u_dut32.filt[2]), 32'h1);
                            chk("irq_e3",  32'(irq32), 32'h0);
        @(posedge clk); #1; chk("irq_e4",  32'(irq32), 32'h0);
        @(posedge clk); #1; chk("irq_e5",  32'(irq32), 32'h1);
        rd_exp(1'b0, 32'h20, 32'h4, "stat_rise");
        rd_exp(1'b0, 32'h14, 32'h4, "in_rise");
        apb_wr(1'b0, 32'h20, 32'h4);
        chk("irq_w1c0", 32'(irq32), 32'h1);
        @(posedge clk); #1; chk("irq_w1c1", 32'(irq32), 32'h0);
        rd_exp(1'b0, 32'h20, 32'h0, "stat_w1c");

        // debounce DB=3: a 6-cycle glitch never sees three agreeing ticks
        apb_wr(1'b0, 32'h18, 32'h5);
        apb_wr(1'b0, 32'h24, 32'h3);
        @(posedge clk); #1; gin32[0] = 1'b1;
        repeat (6) @(posedge clk);
        #1; gin32[0] = 1'b0;
        repeat (30) @(posedge clk);
        rd_exp(1'b0, 32'h14, 32'h4, "in_glitch");
        rd_exp(1'b0, 32'h20, 32'h0, "stat_glitch");
        // sustained level: 2 sync edges + three ticks 4 apart -> edge 11..14
        @(posedge clk); #1; gin32[0] = 1'b1;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (u_dut32.filt[0] && k == 0) k = i;
        end
        chk("db_lat_ok", 32'(k >= 11 && k <= 16), 32'h1);
        rd_exp(1'b0, 32'h14, 32'h5, "in_db");
        rd_exp(1'b0, 32'h20, 32'h1, "stat_db");
        chk("irq_db", 32'(irq32), 32'h1);

        // fall event and W1C of the same bit in the same cycle
        apb_wr(1'b0, 32'h24, 32'h0);
        apb_wr(1'b0, 32'h1C, 32'h1);
        @(posedge clk); #1; gin32[0] = 1'b0;
        @(posedge clk);
        apb_wr(1'b0, 32'h20, 32'h1);
        chk("irq_race0", 32'(irq32), 32'h1);
        @(posedge clk); #1; chk("irq_race1", 32'(irq32), 32'h1);
        rd_exp(1'b0, 32'h20, 32'h1, "stat_race");

        // N=8 masking
        apb_wr(1'b1, 32'h00, 32'hFFFFFFFF);
        apb_wr(1'b1, 32'h10, 32'hFFFFFFFF);
        apb_wr(1'b1, 32'h18, 32'hFFFFFFFF);
        rd_exp(1'b1, 32'h00, 32'hFF, "n8_out");
        rd_exp(1'b1, 32'h10, 32'hFF, "n8_oe");
        rd_exp(1'b1, 32'h18, 32'hFF, "n8_rise");
        rd_exp(1'b1, 32'h30, 32'h0, "n8_hole");

        // reset during the access phase of a write to OUT
        @(posedge clk); #1;
        drv(1'b1, 1'b1, 1'b0, 1'b1, 32'h00, 32'h0000003C);
        @(posedge clk); #1;
        drv(1'b1, 1'b1, 1'b1, 1'b1, 32'h00, 32'h0000003C);
        #2; rst8_n = 1'b0;
        #1; drv(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        #1; chk("n8_rst_gout", 32'(gout8), 32'hA5);
            chk("n8_rst_goe",  32'(goe8),  32'h0);
        @(posedge clk); #1; rst8_n = 1'b1;
        rd_exp(1'b1, 32'h00, 32'hA5, "n8_rst_out");
        rd_exp(1'b1, 32'h10, 32'h0,  "n8_rst_oe");
        rd_exp(1'b1, 32'h18, 32'h0,  "n8_rst_rise");
        chk("n8_irq", 32'(irq8), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
